// File: rtl/mips_dbg_pkg.sv
// ----------------------------------------------------------------------------
// mips_dbg_pkg
// Shared definitions for the MIPS debug/run controller and the display mux
// in mips_fpga: the 2-bit run-state encodings and a breakpoint-match helper.
// ----------------------------------------------------------------------------
package mips_dbg_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] run_state_t;

    localparam run_state_t ST_IDLE  = 2'b00;
    localparam run_state_t ST_STEP  = 2'b01;
    localparam run_state_t ST_RUN   = 2'b10;
    localparam run_state_t ST_BREAK = 2'b11;

    // True when the breakpoint is armed and the PC about to execute matches it.
    function automatic logic bp_match(input logic        en,
                                      input logic [31:0] pc,
                                      input logic [31:0] addr);
        return en & (pc == addr);
    endfunction

endpackage

// File: rtl/mips_run_ctrl_rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect
// Registers a synchronous level input and produces a one-cycle pulse on its
// rising edge, so a held button yields a single event.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset (clears the history register)
//   i_level  level input, synchronous to clk
//   o_rise   i_level & ~(i_level delayed one cycle)
// ----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;

    // History register: previous-cycle value of the level input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// ----------------------------------------------------------------------------
// mips_run_ctrl
// Execution controller for the MIPS core: produces a one-cycle clock-enable
// (cpu_en) for mips_top. Supports single-step per button press, free-run at
// one pulse every RUN_DIV clocks, and a PC breakpoint that halts before the
// matching instruction executes.
// Ports:
//   clk         system clock (100 MHz)
//   rst         asynchronous active-low reset
//   step_btn    debounced step button (level, synchronous)
//   run_sw      run switch, 1 = free-run requested
//   bp_en       breakpoint enable
//   bp_addr     breakpoint PC value
//   pc_current  PC of the next instruction mips_top will execute
//   cpu_en      one-cycle clock-enable pulse (registered)
//   halted      1 while in BREAK (registered)
//   state       IDLE=00, STEP=01, RUN=10, BREAK=11 (registered)
//   cycle_cnt   number of cpu_en pulses issued, wraps (registered)
// ----------------------------------------------------------------------------
module mips_run_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int RUN_DIV = 5000000,
    parameter int DIV_W   = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_current,
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             w_step_edge;
    logic             w_div_last;
    logic             w_bp_hit;
    run_state_t       w_state_nxt;
    logic             w_cpu_en_nxt;
    logic [DIV_W-1:0] w_div_nxt;

    run_state_t       r_state;
    logic             r_cpu_en;
    logic             r_halted;
    logic [31:0]      r_cycle_cnt;
    logic [DIV_W-1:0] r_div;

    rise_detect u_step_rise (
        .clk     (clk),
        .rst     (rst),
        .i_level (step_btn),
        .o_rise  (w_step_edge)
    );

    assign w_div_last = (r_div == DIV_LAST);
    assign w_bp_hit   = bp_match(bp_en, pc_current, bp_addr);

    // Next-state, pulse and divider decode. The pulse is decided here and
    // registered, so cpu_en is high during the cycle following the decision;
    // the PC seen at the decision edge is the instruction that pulse runs.
    always_comb begin
        w_state_nxt  = r_state;
        w_cpu_en_nxt = 1'b0;
        w_div_nxt    = {DIV_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                // Run request wins; a coincident step edge is dropped.
                if (run_sw) begin
                    w_state_nxt = ST_RUN;
                end else if (w_step_edge) begin
                    w_state_nxt  = ST_STEP;
                    w_cpu_en_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                // Dropping run_sw overrides a terminal count in the same cycle.
                if (!run_sw) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_div_last) begin
                    if (w_bp_hit) begin
                        w_state_nxt = ST_BREAK;
                    end else begin
                        w_state_nxt  = ST_RUN;
                        w_cpu_en_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = r_div + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            ST_BREAK: begin
                // Leaving via run_sw=0 beats a coincident step edge.
                if (!run_sw) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_step_edge) begin
                    w_state_nxt  = ST_STEP;
                    w_cpu_en_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_BREAK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pulse, halt flag and divider registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b0;
            r_div    <= {DIV_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_cpu_en <= w_cpu_en_nxt;
            r_halted <= (w_state_nxt == ST_BREAK);
            r_div    <= w_div_nxt;
        end
    end

    // Pulse counter: a pulse is counted at the end of its enable cycle, so a
    // reset that cuts a pulse short leaves it uncounted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= 32'd0;
        end else if (r_cpu_en) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end else begin
            r_cycle_cnt <= r_cycle_cnt;
        end
    end

    assign cpu_en    = r_cpu_en;
    assign halted    = r_halted;
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_run_ctrl
// Scoreboard bench for mips_run_ctrl with RUN_DIV=4. The stimulus process
// drives inputs on the falling edge, advances a behavioural model of the
// controller and queues the outputs expected after the next rising edge; a
// monitor pops and compares them just after each rising edge. The model also
// plays mips_top's PC: it advances by 4 at the end of every pulse it expects.
// ----------------------------------------------------------------------------
module tb_mips_run_ctrl;

    localparam int RUN_DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_STEP  = 1;
    localparam int M_RUN   = 2;
    localparam int M_BREAK = 3;

    typedef struct packed {
        logic        en;
        logic        halted;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        step_btn;
    logic        run_sw;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_current;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    // Behavioural model
    int          m_mode;
    int          m_age;
    logic        m_en;
    logic [31:0] m_cnt;
    logic [31:0] m_pc;
    logic        m_prev_btn;

    mips_run_ctrl #(.RUN_DIV(RUN_DIV), .DIV_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_btn   (step_btn),
        .run_sw     (run_sw),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_current (pc_current),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .state      (state),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_age      = 0;
        m_en       = 1'b0;
        m_cnt      = 32'd0;
        m_pc       = 32'd0;
        m_prev_btn = 1'b0;
    endtask

    // One clock of the controller as described in words: what the button,
    // switch and breakpoint do in each mode, with run pulses every RUN_DIV
    // cycles counted from entering RUN.
    task automatic model_step(input logic run, input logic btn, input logic bpen,
                              input logic [31:0] bpa, input logic [31:0] pc);
        logic rise;
        logic fire;
        int   nmode;
        rise       = btn && !m_prev_btn;
        m_prev_btn = btn;
        fire       = 1'b0;
        nmode      = m_mode;
        case (m_mode)
            M_IDLE: begin
                if (run) begin
                    nmode = M_RUN;
                    m_age = 0;
                end else if (rise) begin
                    nmode = M_STEP;
                    fire  = 1'b1;
                end
            end
            M_STEP: nmode = M_IDLE;
            M_RUN: begin
                if (!run) begin
                    nmode = M_IDLE;
                end else begin
                    m_age++;
                    if (m_age % RUN_DIV == 0) begin
                        if (bpen && pc == bpa) nmode = M_BREAK;
                        else fire = 1'b1;
                    end
                end
            end
            M_BREAK: begin
                if (!run) begin
                    nmode = M_IDLE;
                end else if (rise) begin
                    nmode = M_STEP;
                    fire  = 1'b1;
                end
            end
            default: nmode = M_IDLE;
        endcase
        // The pulse currently on cpu_en completes at this edge.
        if (m_en) begin
            m_cnt = m_cnt + 32'd1;
            m_pc  = m_pc + 32'd4;
        end
        m_en   = fire;
        m_mode = nmode;
    endtask

    task automatic cycle(input logic run, input logic btn, input logic bpen,
                         input logic [31:0] bpa);
        exp_t e;
        @(negedge clk);
        run_sw     = run;
        step_btn   = btn;
        bp_en      = bpen;
        bp_addr    = bpa;
        pc_current = m_pc;
        model_step(run, btn, bpen, bpa, m_pc);
        e.en     = m_en;
        e.halted = (m_mode == M_BREAK);
        e.st     = 2'(m_mode);
        e.cnt    = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run_sw     = 1'b0;
        step_btn   = 1'b0;
        pc_current = 32'd0;
        rst        = 1'b0;
        model_reset();
        #1;
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (cpu_en !== e.en || halted !== e.halted || state !== e.st ||
                    cycle_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL sb: got en=%0b halt=%0b st=%0d cnt=%0h, expected en=%0b halt=%0b st=%0d cnt=%0h (t=%0t)",
                             cpu_en, halted, state, cycle_cnt, e.en, e.halted, e.st, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        logic        r_run;
        logic        r_btn;
        logic        r_bpen;
        logic [31:0] r_bpa;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        step_btn   = 1'b0;
        run_sw     = 1'b0;
        bp_en      = 1'b0;
        bp_addr    = 32'd0;
        pc_current = 32'd0;
        model_reset();

        // 1: reset then idle
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        chk("idle_state", {30'd0, state}, 32'd0);
        chk("idle_cnt", cycle_cnt, 32'd0);

        // 2: held button gives one step
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        chk("step_cnt", cycle_cnt, 32'd1);
        chk("step_state", {30'd0, state}, 32'd0);

        // 3: free run, three pulses then stop
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        chk("run_stop_state", {30'd0, state}, 32'd0);
        chk("run_stop_en", {31'd0, cpu_en}, 32'd0);
        chk("run_cnt", cycle_cnt, 32'd3);

        // 4: breakpoint at 0x0C
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 32'h0000_000C);
        settle();
        chk("bp_state", {30'd0, state}, 32'd3);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_cnt", cycle_cnt, 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_000C);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_000C);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_000C);
        settle();
        chk("bp_step_cnt", cycle_cnt, 32'd4);
        chk("bp_resume_state", {30'd0, state}, 32'd2);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);

        // 5a: step edge with run rising in IDLE -> RUN, no pulse
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        settle();
        chk("sim_idle_state", {30'd0, state}, 32'd2);
        chk("sim_idle_en", {31'd0, cpu_en}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);

        // 5b: step edge with run low in BREAK -> IDLE, no pulse
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 32'd0);
        settle();
        chk("sim_brk_pre", {30'd0, state}, 32'd3);
        cycle(1'b0, 1'b1, 1'b1, 32'd0);
        settle();
        chk("sim_brk_state", {30'd0, state}, 32'd0);
        chk("sim_brk_en", {31'd0, cpu_en}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);

        // 6a: counter wrap
        do_reset();
        @(negedge clk);
        force dut.r_cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle_cnt;
        m_cnt = 32'hFFFF_FFFF;
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        chk("wrap_cnt", cycle_cnt, 32'd0);

        // 6b: async reset during a run pulse
        do_reset();
        for (int i = 0; i < 20 && !m_en; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        if (!m_en) chk("arst_no_pulse_reached", 32'd0, 32'd1);
        settle();
        chk("arst_pre_en", {31'd0, cpu_en}, 32'd1);
        rst    = 1'b0;
        run_sw = 1'b0;
        #1;
        chk("arst_en", {31'd0, cpu_en}, 32'd0);
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_cnt", cycle_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomised traffic against the model
        do_reset();
        r_run  = 1'b0;
        r_btn  = 1'b0;
        r_bpen = 1'b0;
        r_bpa  = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) r_run = ~r_run;
            if ($urandom_range(0, 5) == 0) r_btn = ~r_btn;
            if ($urandom_range(0, 49) == 0) r_bpen = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) r_bpa = m_pc + 32'(4 * $urandom_range(0, 3));
            cycle(r_run, r_btn, r_bpen, r_bpa);
        end
        settle();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
